// File: rtl/roi_pkg.sv
// Shared ROI constants and FSM state type, also used by the overlay and the downsample writer.
package roi_pkg;

    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BOX_SIZE = 224;
    localparam int STEP     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } roi_state_t;

    // Exclusive far edge of the box for a given near edge.
    function automatic logic [COORD_W-1:0] box_far_edge(input logic [COORD_W-1:0] near_edge);
        return near_edge + COORD_W'(BOX_SIZE);
    endfunction

endpackage

// File: rtl/roi_axis_step.sv
// One axis of the shadow ROI position: +/- STEP_SZ per pulse, saturating to [0, MAX].
module roi_axis_step
    import roi_pkg::*;
#(
    parameter int MAX     = 416,
    parameter int STEP_SZ = 8,
    parameter int INIT    = 208
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_dec,
    input  logic               i_inc,
    output logic [COORD_W-1:0] o_pos
);

    logic [COORD_W-1:0] r_pos;
    logic [COORD_W-1:0] w_pos_next;
    logic [COORD_W:0]   w_up_sum;

    // One extra bit so the overshoot test cannot wrap.
    assign w_up_sum = {1'b0, r_pos} + (COORD_W+1)'(STEP_SZ);

    always_comb begin
        w_pos_next = r_pos;
        if (i_inc && !i_dec) begin
            w_pos_next = (w_up_sum > (COORD_W+1)'(MAX)) ? COORD_W'(MAX) : w_up_sum[COORD_W-1:0];
        end else if (i_dec && !i_inc) begin
            w_pos_next = (r_pos < COORD_W'(STEP_SZ)) ? '0 : r_pos - COORD_W'(STEP_SZ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= COORD_W'(INIT);
        end else begin
            r_pos <= w_pos_next;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/roi_box_ctrl.sv
// ROI box owner: buffers button moves into frame-aligned box updates and sequences one capture per request.
module roi_box_ctrl
    import roi_pkg::*;
#(
    parameter int H_ACTIVE_P     = H_ACTIVE,
    parameter int V_ACTIVE_P     = V_ACTIVE,
    parameter int BOX_SIZE_P     = BOX_SIZE,
    parameter int STEP_P         = STEP,
    parameter int INIT_LEFT      = 208,
    parameter int INIT_UP        = 128,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               cap_req,
    input  logic               wr_done,
    output logic               wr_start,
    output logic               cap_busy,
    output logic               cap_done,
    output logic               cap_err,
    output logic [COORD_W-1:0] box_left,
    output logic [COORD_W-1:0] box_right,
    output logic [COORD_W-1:0] box_up,
    output logic [COORD_W-1:0] box_down
);

    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

    logic [COORD_W-1:0] w_sh_left;
    logic [COORD_W-1:0] w_sh_up;
    logic               w_apply;

    roi_state_t         r_state;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_wr_start;
    logic               r_cap_done;
    logic               r_cap_err;
    logic [COORD_W-1:0] r_box_left;
    logic [COORD_W-1:0] r_box_right;
    logic [COORD_W-1:0] r_box_up;
    logic [COORD_W-1:0] r_box_down;

    roi_axis_step #(
        .MAX     (H_ACTIVE_P - BOX_SIZE_P),
        .STEP_SZ (STEP_P),
        .INIT    (INIT_LEFT)
    ) u_axis_x (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dec (btn_left),
        .i_inc (btn_right),
        .o_pos (w_sh_left)
    );

    roi_axis_step #(
        .MAX     (V_ACTIVE_P - BOX_SIZE_P),
        .STEP_SZ (STEP_P),
        .INIT    (INIT_UP)
    ) u_axis_y (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dec (btn_up),
        .i_inc (btn_down),
        .o_pos (w_sh_up)
    );

    // Shadow is sampled before any coincident button lands, so that step waits a frame.
    assign w_apply = frame_start && (r_state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_box_left  <= COORD_W'(INIT_LEFT);
            r_box_right <= box_far_edge(COORD_W'(INIT_LEFT));
            r_box_up    <= COORD_W'(INIT_UP);
            r_box_down  <= box_far_edge(COORD_W'(INIT_UP));
        end else if (w_apply) begin
            r_box_left  <= w_sh_left;
            r_box_right <= box_far_edge(w_sh_left);
            r_box_up    <= w_sh_up;
            r_box_down  <= box_far_edge(w_sh_up);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tmo_cnt  <= '0;
            r_wr_start <= 1'b0;
            r_cap_done <= 1'b0;
            r_cap_err  <= 1'b0;
        end else begin
            r_wr_start <= 1'b0;
            r_cap_done <= 1'b0;
            r_cap_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cap_req) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (frame_start) begin
                        r_state    <= ST_RUN;
                        r_wr_start <= 1'b1;
                        r_tmo_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    // Completion outranks a coincident frame boundary.
                    if (wr_done) begin
                        r_state    <= ST_IDLE;
                        r_cap_done <= 1'b1;
                        r_tmo_cnt  <= '0;
                    end else if (frame_start) begin
                        if (r_tmo_cnt == CNT_W'(TIMEOUT_FRAMES - 1)) begin
                            r_state   <= ST_IDLE;
                            r_cap_err <= 1'b1;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_start  = r_wr_start;
    assign cap_busy  = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign cap_done  = r_cap_done;
    assign cap_err   = r_cap_err;
    assign box_left  = r_box_left;
    assign box_right = r_box_right;
    assign box_up    = r_box_up;
    assign box_down  = r_box_down;

endmodule

// File: tb/tb_roi_box_ctrl.sv
// Directed bench for roi_box_ctrl: box moves, clamping, frame-aligned apply and capture sequencing.
module tb_roi_box_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       cap_req;
    logic       wr_done;
    logic       wr_start;
    logic       cap_busy;
    logic       cap_done;
    logic       cap_err;
    logic [9:0] box_left;
    logic [9:0] box_right;
    logic [9:0] box_up;
    logic [9:0] box_down;

    int checks   = 0;
    int failures = 0;

    roi_box_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .cap_req     (cap_req),
        .wr_done     (wr_done),
        .wr_start    (wr_start),
        .cap_busy    (cap_busy),
        .cap_done    (cap_done),
        .cap_err     (cap_err),
        .box_left    (box_left),
        .box_right   (box_right),
        .box_up      (box_up),
        .box_down    (box_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_req();
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_held got=%0b exp=0", cap_busy);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (box_left !== 10'd208 || box_right !== 10'd432) begin
            failures++;
            $display("FAIL reset_box_x got=%0d/%0d exp=208/432", box_left, box_right);
        end
        checks++;
        if (box_up !== 10'd128 || box_down !== 10'd352) begin
            failures++;
            $display("FAIL reset_box_y got=%0d/%0d exp=128/352", box_up, box_down);
        end
        checks++;
        if ({wr_start, cap_busy, cap_done, cap_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {wr_start, cap_busy, cap_done, cap_err});
        end
        $display("test_reset: box=%0d/%0d/%0d/%0d", box_left, box_right, box_up, box_down);
    endtask

    task automatic test_move_left();
        for (int i = 0; i < 30; i++) begin
            btn_left = 1'b1;
            tick(1);
            btn_left = 1'b0;
            tick(1);
        end
        checks++;
        if (box_left !== 10'd208) begin
            failures++;
            $display("FAIL left_before_fs got=%0d exp=208", box_left);
        end
        pulse_fs();
        checks++;
        if (box_left !== 10'd0 || box_right !== 10'd224 || box_up !== 10'd128) begin
            failures++;
            $display("FAIL left_clamp got=%0d/%0d/%0d exp=0/224/128", box_left, box_right, box_up);
        end
        $display("test_move_left: box_left=%0d box_right=%0d", box_left, box_right);
    endtask

    task automatic test_move_down();
        for (int i = 0; i < 60; i++) begin
            btn_down = 1'b1;
            tick(1);
            btn_down = 1'b0;
        end
        tick(1);
        pulse_fs();
        checks++;
        if (box_up !== 10'd256 || box_down !== 10'd480) begin
            failures++;
            $display("FAIL down_clamp got=%0d/%0d exp=256/480", box_up, box_down);
        end
        $display("test_move_down: box_up=%0d box_down=%0d", box_up, box_down);
    endtask

    task automatic test_cancel_orthogonal();
        btn_left = 1'b1; btn_right = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
        tick(1);
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(1);
        pulse_fs();
        checks++;
        if (box_left !== 10'd0 || box_up !== 10'd256) begin
            failures++;
            $display("FAIL cancel got=%0d/%0d exp=0/256", box_left, box_up);
        end
        btn_right = 1'b1; btn_up = 1'b1;
        tick(1);
        btn_right = 1'b0; btn_up = 1'b0;
        tick(1);
        pulse_fs();
        checks++;
        if (box_left !== 10'd8 || box_right !== 10'd232 || box_up !== 10'd248 || box_down !== 10'd472) begin
            failures++;
            $display("FAIL orthogonal got=%0d/%0d/%0d/%0d exp=8/232/248/472",
                     box_left, box_right, box_up, box_down);
        end
        $display("test_cancel_orthogonal: box_left=%0d box_up=%0d", box_left, box_up);
    endtask

    task automatic test_capture();
        pulse_req();
        checks++;
        if (cap_busy !== 1'b1 || wr_start !== 1'b0) begin
            failures++;
            $display("FAIL cap_arm got busy=%0b wr_start=%0b exp busy=1 wr_start=0", cap_busy, wr_start);
        end
        tick(99);
        pulse_fs();
        checks++;
        if (wr_start !== 1'b1) begin
            failures++;
            $display("FAIL cap_wr_start got=%0b exp=1", wr_start);
        end
        tick(1);
        checks++;
        if (wr_start !== 1'b0 || cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL cap_wr_start_width got wr_start=%0b busy=%0b exp 0/1", wr_start, cap_busy);
        end
        tick(49);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        checks++;
        if (cap_done !== 1'b1 || cap_busy !== 1'b0 || cap_err !== 1'b0) begin
            failures++;
            $display("FAIL cap_done got done=%0b busy=%0b err=%0b exp 1/0/0", cap_done, cap_busy, cap_err);
        end
        tick(1);
        checks++;
        if (cap_done !== 1'b0) begin
            failures++;
            $display("FAIL cap_done_width got=%0b exp=0", cap_done);
        end
        $display("test_capture: done seen, busy=%0b", cap_busy);
    endtask

    task automatic test_run_freeze();
        pulse_req();
        tick(5);
        pulse_fs();
        checks++;
        if (wr_start !== 1'b1 || box_left !== 10'd8) begin
            failures++;
            $display("FAIL freeze_start got wr_start=%0b left=%0d exp 1/8", wr_start, box_left);
        end
        for (int i = 0; i < 3; i++) begin
            btn_right = 1'b1;
            tick(1);
            btn_right = 1'b0;
        end
        pulse_req();
        tick(3);
        pulse_fs();
        tick(3);
        pulse_fs();
        checks++;
        if (box_left !== 10'd8 || box_right !== 10'd232 || cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL freeze_hold got=%0d/%0d busy=%0b exp=8/232 busy=1", box_left, box_right, cap_busy);
        end
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        checks++;
        if (cap_done !== 1'b1) begin
            failures++;
            $display("FAIL freeze_done got=%0b exp=1", cap_done);
        end
        tick(3);
        pulse_fs();
        checks++;
        if (box_left !== 10'd32 || box_right !== 10'd256) begin
            failures++;
            $display("FAIL freeze_apply got=%0d/%0d exp=32/256", box_left, box_right);
        end
        checks++;
        if (wr_start !== 1'b0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL req_not_queued got wr_start=%0b busy=%0b exp 0/0", wr_start, cap_busy);
        end
        $display("test_run_freeze: box_left=%0d after release", box_left);
    endtask

    task automatic test_timeout();
        pulse_req();
        tick(2);
        pulse_fs();
        for (int k = 1; k <= 3; k++) begin
            tick(10);
            pulse_fs();
            checks++;
            if (cap_err !== 1'b0 || cap_busy !== 1'b1) begin
                failures++;
                $display("FAIL tmo_early_%0d got err=%0b busy=%0b exp 0/1", k, cap_err, cap_busy);
            end
        end
        tick(10);
        pulse_fs();
        checks++;
        if (cap_err !== 1'b1 || cap_busy !== 1'b0 || cap_done !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err got err=%0b busy=%0b done=%0b exp 1/0/0", cap_err, cap_busy, cap_done);
        end
        tick(1);
        checks++;
        if (cap_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err_width got=%0b exp=0", cap_err);
        end
        $display("test_timeout: err pulse on 4th frame");

        pulse_req();
        tick(2);
        pulse_fs();
        for (int k = 1; k <= 3; k++) begin
            tick(10);
            pulse_fs();
        end
        tick(10);
        frame_start = 1'b1;
        wr_done     = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wr_done     = 1'b0;
        checks++;
        if (cap_done !== 1'b1 || cap_err !== 1'b0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_wins got done=%0b err=%0b busy=%0b exp 1/0/0", cap_done, cap_err, cap_busy);
        end
        tick(1);
        checks++;
        if (cap_err !== 1'b0) begin
            failures++;
            $display("FAIL done_wins_no_err got=%0b exp=0", cap_err);
        end
        $display("test_timeout: done wins on coincident 4th frame");
    endtask

    task automatic test_coincide();
        btn_right   = 1'b1;
        frame_start = 1'b1;
        cap_req     = 1'b1;
        tick(1);
        btn_right   = 1'b0;
        frame_start = 1'b0;
        cap_req     = 1'b0;
        checks++;
        if (box_left !== 10'd32 || cap_busy !== 1'b1 || wr_start !== 1'b0) begin
            failures++;
            $display("FAIL coincide_arm got left=%0d busy=%0b wr_start=%0b exp 32/1/0",
                     box_left, cap_busy, wr_start);
        end
        tick(5);
        pulse_fs();
        checks++;
        if (box_left !== 10'd40 || box_right !== 10'd264 || wr_start !== 1'b1) begin
            failures++;
            $display("FAIL coincide_run got=%0d/%0d wr_start=%0b exp 40/264/1", box_left, box_right, wr_start);
        end
        tick(2);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        tick(2);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        checks++;
        if (cap_done !== 1'b0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_wr_done got done=%0b busy=%0b exp 0/0", cap_done, cap_busy);
        end
        $display("test_coincide: box_left=%0d", box_left);
    endtask

    task automatic test_reset_mid();
        pulse_req();
        tick(2);
        pulse_fs();
        btn_left = 1'b1;
        tick(1);
        btn_left = 1'b0;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cap_busy !== 1'b0 || wr_start !== 1'b0 || box_left !== 10'd208 || box_up !== 10'd128) begin
            failures++;
            $display("FAIL reset_mid got busy=%0b wr_start=%0b box=%0d/%0d exp 0/0/208/128",
                     cap_busy, wr_start, box_left, box_up);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        checks++;
        if (cap_done !== 1'b0 || cap_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pulse got done=%0b err=%0b exp 0/0", cap_done, cap_err);
        end
        pulse_fs();
        checks++;
        if (wr_start !== 1'b0 || box_left !== 10'd208 || box_down !== 10'd352) begin
            failures++;
            $display("FAIL reset_mid_discard got wr_start=%0b left=%0d down=%0d exp 0/208/352",
                     wr_start, box_left, box_down);
        end
        $display("test_reset_mid: box_left=%0d busy=%0b", box_left, cap_busy);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        btn_left    = 1'b0;
        btn_right   = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        cap_req     = 1'b0;
        wr_done     = 1'b0;
        test_reset();
        test_move_left();
        test_move_down();
        test_cancel_orthogonal();
        test_capture();
        test_run_freeze();
        test_timeout();
        test_coincide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roi_box_ctrl.md
Name: roi_box_ctrl

Overview:
- Owns the 28x28 CNN region of interest on the 640x480 camera frame.
- Accepts button-step move commands and applies them only at frame boundaries, so the drawn overlay box and the downsample writer never see a mid-frame change.
- Sequences one ROI capture per request: waits for the next frame start, kicks the downsample writer, then waits for its done pulse with a frame-count timeout.
- Sits between the button debouncers, the HDMI box overlay and the ROI downsample writer; its box outputs drive both consumers.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BOX_SIZE, 224, box edge in pixels (28 x 8 downsample).
- STEP, 8, pixels moved per button pulse.
- INIT_LEFT, 208, reset left edge.
- INIT_UP, 128, reset top edge.
- TIMEOUT_FRAMES, 4, frame starts tolerated in RUN before error.

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, start of vertical blanking
- btn_left  in  1  one-cycle debounced pulse
- btn_right  in  1  one-cycle debounced pulse
- btn_up  in  1  one-cycle debounced pulse
- btn_down  in  1  one-cycle debounced pulse
- cap_req  in  1  one-cycle capture request
- wr_done  in  1  one-cycle pulse from downsample writer
- wr_start  out  1  one-cycle pulse to downsample writer
- cap_busy  out  1  high in ARM or RUN
- cap_done  out  1  one-cycle success pulse
- cap_err  out  1  one-cycle timeout pulse
- box_left  out  10  active left edge
- box_right  out  10  box_left + BOX_SIZE, exclusive
- box_up  out  10  active top edge
- box_down  out  10  box_up + BOX_SIZE, exclusive

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: shadow and active left = INIT_LEFT, up = INIT_UP. State IDLE, timeout counter 0. wr_start, cap_busy, cap_done and cap_err all 0.
- Shadow position:
  - Updated the cycle after a button pulse.
  - left decreases or right increases shadow_left by STEP; up/down act on shadow_up the same way.
  - Saturating clamp to [0, H_ACTIVE-BOX_SIZE] horizontally and [0, V_ACTIVE-BOX_SIZE] vertically. With defaults: left 0..416, up 0..256. A step that would overshoot lands exactly on the bound.
  - btn_left and btn_right in the same cycle cancel; likewise up and down. Orthogonal pulses in one cycle both apply.
  - Shadow accepts buttons in all states.
- Active position:
  - Copied from the shadow at a frame_start edge when state is IDLE or ARM.
  - Frozen in RUN.
  - If a button pulse and frame_start coincide, the pre-button shadow is copied; the step lands next frame.
- Box outputs:
  - Registered.
  - right/down computed from the active registers with 10-bit unsigned add. Never overflows, given the clamp.
- FSM, IDLE -> ARM -> RUN -> IDLE:
  - IDLE: cap_req -> ARM next cycle.
  - ARM: on frame_start, active box updates and wr_start pulses 1 cycle later, together with the entry into RUN. The counter clears. The writer therefore sees the new box from its first cycle.
  - RUN, wr_done: pulse cap_done next cycle, go to IDLE.
  - RUN, frame_start: increment the counter. On reaching TIMEOUT_FRAMES, pulse cap_err next cycle and go to IDLE.
  - RUN, wr_done and frame_start in the same cycle: done wins; no count, no error.
- cap_req handling: ignored while cap_busy; not queued.
- cap_req and frame_start in the same cycle in IDLE: box applies; go to ARM; capture waits for the following frame_start.
- wr_done outside RUN: ignored.
- Reset mid-operation: all state returns to reset values immediately, no pulses emitted, and a pending capture is discarded.
- Latency: cap_req to wr_start is at most one frame plus 2 cycles.

Decomposition:
- Shared package roi_pkg holds:
  - FSM state enum
  - default H_ACTIVE, V_ACTIVE, BOX_SIZE, STEP
  - coordinate width 10
- Same constants are used by the downsample writer and the overlay instance.
- One sub-module, roi_axis_step: a single-axis saturating step/clamp register with parameters MAX and STEP. Instantiated twice (x, y).

Test Plan:
- Reset, no stimulus -> box = 208/432/128/352; wr_start=0, cap_busy=0.
- 30 btn_left pulses then frame_start -> box_left=0, box_right=224. Outputs unchanged before frame_start.
- 60 btn_down pulses, frame_start -> box_up=256, box_down=480. btn_left+btn_right same cycle -> no change.
- cap_req, then frame_start 100 cycles later -> wr_start high exactly 1 cycle after frame_start. wr_done 50 cycles later -> cap_done 1 cycle later, cap_busy low.
- In RUN, btn_right pulses plus 2 frame_starts -> box frozen. After completion, next frame_start applies the +8-per-pulse shift.
- Capture with wr_done never asserted -> cap_err on the 4th frame_start in RUN. Second case: wr_done coincident with the 4th frame_start -> cap_done, no cap_err.
